// File: rtl/stopwatch_ctrl.sv
// Stopwatch sequencer: debounces three raw buttons into press pulses and drives
// an external BCD Counter (init/enable), with lap freeze and optional stop at 99.
//
// state     | meaning
// ----------+-------------------------------------------------------------
// S_IDLE    | counter stopped and cleared, waiting for start
// S_RUNNING | counter enabled, display follows time_reading
// S_LAP     | counter enabled, display frozen on captured lap value
// S_PAUSED  | counter stopped, reading held; only clear leaves after max
module stopwatch_ctrl #(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter bit STOP_AT_MAX     = 1'b1
) (
  input  logic       clk,
  input  logic       init_regs,
  input  logic       btn_start_stop,
  input  logic       btn_clear,
  input  logic       btn_lap,
  input  logic [7:0] time_reading,
  output logic       counter_init,
  output logic       counter_enable,
  output logic [7:0] display_value,
  output logic       lap_active,
  output logic       max_reached
);

  localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_TC = CW'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_RUNNING = 2'd1,
    S_LAP     = 2'd2,
    S_PAUSED  = 2'd3
  } state_t;

  // bit 0 = start/stop, bit 1 = clear, bit 2 = lap
  logic [2:0]         btn_raw;
  logic [2:0]         sync1;
  logic [2:0]         sync2;
  logic [1:0]         sync_vld;
  logic [2:0]         level;
  logic [2:0]         level_d;
  logic [2:0]         armed;
  logic [2:0]         press;
  logic [2:0][CW-1:0] db_cnt;

  state_t     state;
  logic [7:0] lap_reg;
  logic       ev_clear;
  logic       ev_ss;
  logic       ev_lap;
  logic       at_max;

  assign btn_raw = {btn_lap, btn_clear, btn_start_stop};

  // A button is armed only after it has been seen released since reset, so a
  // button held through reset cannot produce a press until pressed again.
  always_ff @(posedge clk) begin
    if (!init_regs) begin
      sync1    <= '0;
      sync2    <= '0;
      sync_vld <= '0;
      level    <= '0;
      level_d  <= '0;
      armed    <= '0;
      press    <= '0;
      db_cnt   <= '0;
    end else begin
      sync1    <= btn_raw;
      sync2    <= sync1;
      sync_vld <= {sync_vld[0], 1'b1};
      level_d  <= level;
      press    <= level & ~level_d & armed;
      for (int i = 0; i < 3; i++) begin
        if (sync2[i] == level[i]) begin
          db_cnt[i] <= '0;
        end else if (db_cnt[i] == CNT_TC) begin
          level[i]  <= sync2[i];
          db_cnt[i] <= '0;
        end else begin
          db_cnt[i] <= db_cnt[i] + 1'b1;
        end
        if (sync_vld[1] && !sync2[i] && !level[i]) begin
          armed[i] <= 1'b1;
        end
      end
    end
  end

  // Highest-priority pulse wins; the others in the same cycle are dropped.
  assign ev_clear = press[1];
  assign ev_ss    = press[0] & ~press[1];
  assign ev_lap   = press[2] & ~press[1] & ~press[0];
  assign at_max   = STOP_AT_MAX && (time_reading == 8'h99);

  always_ff @(posedge clk) begin
    if (!init_regs) begin
      state          <= S_IDLE;
      counter_init   <= 1'b1;
      counter_enable <= 1'b0;
      lap_reg        <= 8'h00;
      lap_active     <= 1'b0;
      max_reached    <= 1'b0;
    end else begin
      counter_init <= 1'b0;
      case (state)
        S_IDLE: begin
          if (ev_clear) begin
            counter_init <= 1'b1;
            max_reached  <= 1'b0;
          end else if (ev_ss) begin
            state          <= S_RUNNING;
            counter_enable <= 1'b1;
          end
        end
        S_RUNNING: begin
          if (at_max) begin
            state          <= S_PAUSED;
            counter_enable <= 1'b0;
            max_reached    <= 1'b1;
          end else if (ev_ss) begin
            state          <= S_PAUSED;
            counter_enable <= 1'b0;
          end else if (ev_lap) begin
            state      <= S_LAP;
            lap_active <= 1'b1;
            lap_reg    <= time_reading;
          end
        end
        S_LAP: begin
          if (at_max) begin
            state          <= S_PAUSED;
            counter_enable <= 1'b0;
            lap_active     <= 1'b0;
            max_reached    <= 1'b1;
          end else if (ev_ss) begin
            state          <= S_PAUSED;
            counter_enable <= 1'b0;
            lap_active     <= 1'b0;
          end else if (ev_lap) begin
            state      <= S_RUNNING;
            lap_active <= 1'b0;
          end
        end
        S_PAUSED: begin
          if (ev_clear) begin
            state        <= S_IDLE;
            counter_init <= 1'b1;
            max_reached  <= 1'b0;
          end else if (ev_ss && !max_reached) begin
            state          <= S_RUNNING;
            counter_enable <= 1'b1;
          end
        end
        default: begin
          state          <= S_IDLE;
          counter_enable <= 1'b0;
          lap_active     <= 1'b0;
        end
      endcase
    end
  end

  assign display_value = lap_active ? lap_reg : time_reading;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Bench for stopwatch_ctrl: per-cycle expected outputs come from a reference
// model driven by button run lengths; a monitor pops and compares each cycle.
module tb_stopwatch_ctrl;

  localparam int D = 4;

  localparam int MODE_IDLE  = 0;
  localparam int MODE_RUN   = 1;
  localparam int MODE_FROZE = 2;
  localparam int MODE_HOLD  = 3;

  logic       clk = 1'b0;
  logic       init_regs;
  logic       btn_start_stop;
  logic       btn_clear;
  logic       btn_lap;
  logic [7:0] time_reading;
  logic       counter_init;
  logic       counter_enable;
  logic [7:0] display_value;
  logic       lap_active;
  logic       max_reached;

  always #5 clk = ~clk;

  stopwatch_ctrl #(
    .DEBOUNCE_CYCLES(D),
    .STOP_AT_MAX    (1'b1)
  ) dut (
    .clk           (clk),
    .init_regs     (init_regs),
    .btn_start_stop(btn_start_stop),
    .btn_clear     (btn_clear),
    .btn_lap       (btn_lap),
    .time_reading  (time_reading),
    .counter_init  (counter_init),
    .counter_enable(counter_enable),
    .display_value (display_value),
    .lap_active    (lap_active),
    .max_reached   (max_reached)
  );

  typedef struct packed {
    logic       init;
    logic       en;
    logic [7:0] disp;
    logic       lap;
    logic       maxr;
  } exp_t;

  exp_t exp_q[$];
  int   tests = 0;
  int   fails = 0;

  // reference model
  int         m_mode  = MODE_IDLE;
  bit         m_init  = 1'b1;
  bit         m_max   = 1'b0;
  logic [7:0] m_lapv  = 8'h00;
  logic [7:0] m_cnt   = 8'h00;
  bit         tr_auto = 1'b1;
  int         edge_n  = 0;
  bit         b_last[3];
  int         b_run[3];
  bit         b_lvl[3];
  bit         b_armed[3];
  int         b_fire[3];

  function automatic logic [7:0] bcd_inc(input logic [7:0] v);
    if (v == 8'h99) return 8'h00;
    if (v[3:0] == 4'd9) return {v[7:4] + 4'd1, 4'd0};
    return v + 8'd1;
  endfunction

  // Inputs are applied at a falling edge; this models the next rising edge.
  task automatic tick();
    bit [2:0] raw;
    bit [2:0] p;
    bit       init_pre;
    bit       en_pre;
    bit       clr_w, ss_w, lp_w, at_max;
    exp_t     e;
    if (tr_auto) time_reading = m_cnt;
    raw      = {btn_lap, btn_clear, btn_start_stop};
    init_pre = m_init;
    en_pre   = (m_mode == MODE_RUN) || (m_mode == MODE_FROZE);
    if (!init_regs) begin
      m_mode = MODE_IDLE;
      m_init = 1'b1;
      m_max  = 1'b0;
      m_lapv = 8'h00;
      edge_n = 0;
      for (int i = 0; i < 3; i++) begin
        b_last[i] = 1'b0; b_run[i] = 0; b_lvl[i] = 1'b0;
        b_armed[i] = 1'b0; b_fire[i] = -1;
      end
    end else begin
      for (int i = 0; i < 3; i++) p[i] = (b_fire[i] == edge_n);
      clr_w  = p[1];
      ss_w   = p[0] && !p[1];
      lp_w   = p[2] && !p[1] && !p[0];
      at_max = (time_reading == 8'h99);
      m_init = 1'b0;
      if (m_mode == MODE_IDLE) begin
        if (clr_w) begin m_init = 1'b1; m_max = 1'b0; end
        else if (ss_w) m_mode = MODE_RUN;
      end else if (m_mode == MODE_RUN || m_mode == MODE_FROZE) begin
        if (at_max) begin m_mode = MODE_HOLD; m_max = 1'b1; end
        else if (ss_w) m_mode = MODE_HOLD;
        else if (lp_w && m_mode == MODE_RUN) begin m_mode = MODE_FROZE; m_lapv = time_reading; end
        else if (lp_w) m_mode = MODE_RUN;
      end else begin
        if (clr_w) begin m_mode = MODE_IDLE; m_init = 1'b1; m_max = 1'b0; end
        else if (ss_w && !m_max) m_mode = MODE_RUN;
      end
      // press accepted once the raw level has been stable D samples;
      // it reaches the state machine 4 edges after the D-th sample
      for (int i = 0; i < 3; i++) begin
        b_run[i]  = (raw[i] == b_last[i]) ? b_run[i] + 1 : 1;
        b_last[i] = raw[i];
        if (raw[i] != b_lvl[i] && b_run[i] == D) begin
          b_lvl[i] = raw[i];
          if (raw[i] && b_armed[i]) b_fire[i] = edge_n + 4;
        end
        if (!raw[i] && !b_lvl[i]) b_armed[i] = 1'b1;
      end
      edge_n++;
    end
    if (init_pre) m_cnt = 8'h00;
    else if (en_pre) m_cnt = bcd_inc(m_cnt);
    e.init = m_init;
    e.en   = (m_mode == MODE_RUN) || (m_mode == MODE_FROZE);
    e.disp = (m_mode == MODE_FROZE) ? m_lapv : time_reading;
    e.lap  = (m_mode == MODE_FROZE);
    e.maxr = m_max;
    exp_q.push_back(e);
    @(negedge clk);
  endtask

  task automatic hold(input int n);
    repeat (n) tick();
  endtask

  task automatic set_btns(input bit ss, input bit clr, input bit lp);
    btn_start_stop = ss;
    btn_clear      = clr;
    btn_lap        = lp;
  endtask

  task automatic press(input int which, input int hi, input int lo);
    set_btns(which == 0, which == 1, which == 2);
    hold(hi);
    set_btns(0, 0, 0);
    hold(lo);
  endtask

  // monitor: every cycle the DUT presents a new output set
  initial begin
    exp_t e;
    exp_t a;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        a = {counter_init, counter_enable, display_value, lap_active, max_reached};
        tests++;
        if (a !== e) begin
          fails++;
          $display("FAIL outputs t=%0t got init=%b en=%b disp=%h lap=%b max=%b expected init=%b en=%b disp=%h lap=%b max=%b",
                   $time, a.init, a.en, a.disp, a.lap, a.maxr,
                   e.init, e.en, e.disp, e.lap, e.maxr);
        end
      end
    end
  end

  initial begin
    int r;
    init_regs    = 1'b0;
    time_reading = 8'h00;
    set_btns(0, 0, 0);
    @(negedge clk);

    hold(3);
    init_regs = 1'b1;
    hold(6);

    press(0, 10, 10);

    tr_auto = 1'b0;
    time_reading = 8'h23;
    btn_lap = 1'b1;
    hold(8);
    btn_lap = 1'b0;
    for (int v = 8'h24; v <= 8'h27; v++) begin
      time_reading = 8'(v);
      hold(3);
    end
    press(2, 10, 10);
    press(0, 10, 10);

    set_btns(1, 1, 0);
    hold(10);
    set_btns(0, 0, 0);
    hold(10);

    tr_auto = 1'b1;
    press(0, 10, 6);
    tr_auto = 1'b0;
    time_reading = 8'h98;
    hold(3);
    time_reading = 8'h99;
    hold(3);
    press(0, 10, 10);
    press(1, 10, 10);
    tr_auto = 1'b1;

    press(2, 3, 10);

    btn_start_stop = 1'b1;
    init_regs = 1'b0;
    hold(3);
    init_regs = 1'b1;
    hold(12);
    btn_start_stop = 1'b0;
    hold(10);
    press(0, 10, 10);

    for (int it = 0; it < 200; it++) begin
      r = $urandom_range(0, 19);
      if (r == 0) begin
        init_regs = 1'b0;
        hold($urandom_range(1, 3));
        init_regs = 1'b1;
        hold(2);
      end else if (r <= 2) begin
        tr_auto = 1'b0;
        if ($urandom_range(0, 3) == 0) time_reading = 8'h99;
        else time_reading = {4'($urandom_range(0, 9)), 4'($urandom_range(0, 9))};
        hold($urandom_range(2, 6));
        tr_auto = 1'b1;
      end else begin
        press($urandom_range(0, 2), $urandom_range(1, 9), $urandom_range(5, 12));
      end
    end

    hold(3);
    tests++;
    if (exp_q.size() != 0) begin
      fails++;
      $display("FAIL scoreboard_drain got %0d pending entries expected 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/stopwatch_ctrl.md
STOPWATCH_CTRL -- requirements
Module: stopwatch_ctrl

Interface
REQ-001 Parameter: DEBOUNCE_CYCLES, default 1000000 (10 ms at 100 MHz), number of consecutive stable samples needed to accept a button level change.
REQ-002 Parameter: STOP_AT_MAX, default 1; when 1, the block auto-pauses at reading 8'h99.
REQ-003 Port: clk  input  1  system clock, 100 MHz, all logic on rising edge.
REQ-004 Port: init_regs  input  1  reset, synchronous, active-low; sampled only on the rising edge of clk.
REQ-005 Port: btn_start_stop  input  1  raw asynchronous start/stop button, active-high.
REQ-006 Port: btn_clear  input  1  raw asynchronous clear button, active-high.
REQ-007 Port: btn_lap  input  1  raw asynchronous lap/split button, active-high.
REQ-008 Port: time_reading  input  8  BCD value from Counter; [7:4] = tens, [3:0] = ones.
REQ-009 Port: counter_init  output  1  drives Counter init_regs, active-high.
REQ-010 Port: counter_enable  output  1  drives Counter count_enabled.
REQ-011 Port: display_value  output  8  BCD value to display.
REQ-012 Port: lap_active  output  1  high while display_value is frozen.
REQ-013 Port: max_reached  output  1  sticky flag, auto-stop at 99 occurred.

Function
REQ-014 Each button SHALL pass through a 2-flop synchronizer, then a debouncer that changes its output level only after DEBOUNCE_CYCLES consecutive equal samples that differ from the current level.
REQ-015 A one-cycle press pulse SHALL be generated on each debounced 0->1 transition; releases and held buttons generate no further pulses.
REQ-016 The FSM SHALL act on a press exactly DEBOUNCE_CYCLES+3 rising edges after the first edge at which the raw input is sampled high and then held stable.
REQ-017 The FSM SHALL have the states IDLE, RUNNING, LAP and PAUSED, held in a registered state.
REQ-018 IDLE: start_stop -> RUNNING; clear -> IDLE with a counter_init pulse; lap is ignored.
REQ-019 RUNNING: start_stop -> PAUSED; lap -> LAP, capturing time_reading into the lap register on the same edge; clear is ignored.
REQ-020 LAP: lap -> RUNNING, releasing the display; start_stop -> PAUSED, releasing the display; clear is ignored.
REQ-021 PAUSED: start_stop -> RUNNING; clear -> IDLE with a counter_init pulse and max_reached cleared; lap is ignored.
REQ-022 Simultaneous press pulses SHALL be resolved with the priority clear > start_stop > lap; lower-priority pulses in that cycle are discarded.
REQ-023 counter_enable SHALL be a registered output, high exactly in RUNNING and LAP, updated on the same edge as the state register.
REQ-024 counter_init SHALL be a registered output, high for exactly one cycle on the edge that enters IDLE via clear.
REQ-025 display_value SHALL equal the lap register when lap_active = 1, and otherwise equal time_reading (combinational mux).
REQ-026 lap_active SHALL be high exactly in LAP.
REQ-027 With STOP_AT_MAX = 1, in RUNNING or LAP with time_reading == 8'h99:
  - state -> PAUSED on the next edge, display released;
  - max_reached is set;
  - this has priority below clear and above start_stop and lap.
REQ-028 While max_reached = 1, start_stop in PAUSED SHALL be ignored; only clear leaves PAUSED.
REQ-029 With STOP_AT_MAX = 0, 8'h99 SHALL have no special effect; Counter wrap is passed through unchanged.

Reset
REQ-030 On any rising edge with init_regs = 0, the block SHALL set:
  - state = IDLE;
  - counter_init = 1 (held through reset and for the first cycle after release);
  - counter_enable = 0, lap register = 8'h00, lap_active = 0, max_reached = 0;
  - synchronizers, debouncer levels and counters cleared to 0.
REQ-031 A reset asserted mid-operation in any state SHALL take effect on the next edge, and no press pulse SHALL be generated from a button held through reset until it is released and pressed again.

Verification (DEBOUNCE_CYCLES = 4, Counter modelled by bench)
REQ-032 Reset: init_regs low for 3 cycles, then high -> IDLE, counter_enable = 0, counter_init = 1 until 1 cycle after release, display_value = time_reading.
REQ-033 Start/stop: btn_start_stop held 10 cycles -> counter_enable rises exactly 7 edges after the first high sample; a second press -> PAUSED, counter_enable = 0.
REQ-034 Lap: press lap in RUNNING with time_reading = 8'h23, then drive time_reading 8'h24..8'h27 -> display_value stays 8'h23 and lap_active = 1; a second lap press -> display_value = 8'h27.
REQ-035 Clear: in PAUSED, press clear and start_stop together -> IDLE, counter_init high for exactly 1 cycle, counter_enable stays 0.
REQ-036 Max: RUNNING with time_reading driven to 8'h99 -> next edge PAUSED, max_reached = 1; start_stop press ignored; clear -> IDLE, max_reached = 0.
REQ-037 Glitch: btn_lap high for 3 cycles, then low -> no state change, lap_active stays 0.
